// File: rtl/stage_mem_lsu_pkg.sv
// ----------------------------------------------------------------------------
// stage_mem_lsu_pkg
// Shared constants for the MEM-stage load/store unit: ALU op codes for memory
// accesses, access-size and FSM state enums, and the op decode helpers.
// No ports (package).
// ----------------------------------------------------------------------------
package stage_mem_lsu_pkg;

    localparam int unsigned ALUOP_W = 4;

    // Memory op codes; anything not listed here is a plain ALU op.
    localparam logic [ALUOP_W-1:0] OP_ALU = 4'd0;
    localparam logic [ALUOP_W-1:0] OP_LB  = 4'd1;
    localparam logic [ALUOP_W-1:0] OP_LH  = 4'd2;
    localparam logic [ALUOP_W-1:0] OP_LW  = 4'd3;
    localparam logic [ALUOP_W-1:0] OP_LBU = 4'd4;
    localparam logic [ALUOP_W-1:0] OP_LHU = 4'd5;
    localparam logic [ALUOP_W-1:0] OP_LWU = 4'd6;
    localparam logic [ALUOP_W-1:0] OP_LD  = 4'd7;
    localparam logic [ALUOP_W-1:0] OP_SB  = 4'd8;
    localparam logic [ALUOP_W-1:0] OP_SH  = 4'd9;
    localparam logic [ALUOP_W-1:0] OP_SW  = 4'd10;
    localparam logic [ALUOP_W-1:0] OP_SD  = 4'd11;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } size_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_e;

    // LWU/LD/SD only decode as memory ops on a 64-bit datapath.
    function automatic logic is_load(input logic [ALUOP_W-1:0] op, input logic xlen64);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            OP_LWU, OP_LD:                       return xlen64;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [ALUOP_W-1:0] op, input logic xlen64);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            OP_SD:               return xlen64;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [ALUOP_W-1:0] op, input logic xlen64);
        return is_load(op, xlen64) | is_store(op, xlen64);
    endfunction

    function automatic logic op_signed(input logic [ALUOP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    function automatic size_e op_size(input logic [ALUOP_W-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB:  return SZ_B;
            OP_LH, OP_LHU, OP_SH:  return SZ_H;
            OP_LD, OP_SD:          return SZ_D;
            default:               return SZ_W;
        endcase
    endfunction

    // Low byte-address bits that must be zero for a naturally aligned access.
    function automatic logic misaligned(input size_e sz, input logic [2:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            SZ_W:    return |lo[1:0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/stage_mem_lsu_mem_lane_align.sv
// ----------------------------------------------------------------------------
// stage_mem_lsu_mem_lane_align
// Combinational byte-lane steering for the LSU. The lane index is first
// truncated to the access size, so a misaligned address behaves as aligned.
// Ports:
//   i_op       memory op code
//   i_lane     low byte-address bits (lane index)
//   i_st_data  store operand
//   i_rdata    raw memory read data
//   o_be       byte enables for the access
//   o_wdata    store operand replicated across all lanes
//   o_ld_data  extracted and sign/zero-extended load value
// ----------------------------------------------------------------------------
module stage_mem_lsu_mem_lane_align
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ALUOP_W-1:0]        i_op,
    input  logic [$clog2(XLEN/8)-1:0] i_lane,
    input  logic [XLEN-1:0]           i_st_data,
    input  logic [XLEN-1:0]           i_rdata,
    output logic [XLEN/8-1:0]         o_be,
    output logic [XLEN-1:0]           o_wdata,
    output logic [XLEN-1:0]           o_ld_data
);

    localparam int unsigned NB     = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(NB);

    size_e             w_size;
    logic              w_signed;
    logic [LANE_W-1:0] w_mask;
    logic [LANE_W-1:0] w_k;
    logic [NB-1:0]     w_be_base;
    logic [XLEN-1:0]   w_shifted;

    assign w_size   = op_size(i_op);
    assign w_signed = op_signed(i_op);

    // Size-dependent lane mask and unshifted enable pattern.
    always_comb begin
        w_mask    = '0;
        w_be_base = '0;
        case (w_size)
            SZ_B: begin
                w_mask    = LANE_W'(0);
                w_be_base = NB'(1);
            end
            SZ_H: begin
                w_mask    = LANE_W'(1);
                w_be_base = NB'(3);
            end
            SZ_W: begin
                w_mask    = LANE_W'(3);
                w_be_base = NB'(15);
            end
            default: begin
                w_mask    = '1;
                w_be_base = '1;
            end
        endcase
    end

    assign w_k       = i_lane & ~w_mask;
    assign o_be      = w_be_base << w_k;
    assign w_shifted = i_rdata >> {w_k, 3'b000};

    // Replicate the low operand bytes into every lane.
    always_comb begin
        o_wdata = '0;
        for (int b = 0; b < int'(NB); b++) begin
            case (w_size)
                SZ_B:    o_wdata[b*8 +: 8] = i_st_data[7:0];
                SZ_H:    o_wdata[b*8 +: 8] = i_st_data[(b % 2)*8 +: 8];
                SZ_W:    o_wdata[b*8 +: 8] = i_st_data[(b % 4)*8 +: 8];
                default: o_wdata[b*8 +: 8] = i_st_data[b*8 +: 8];
            endcase
        end
    end

    // Extract the addressed lane and extend to full width.
    always_comb begin
        o_ld_data = w_shifted;
        case (w_size)
            SZ_B: o_ld_data = w_signed ? XLEN'($signed(w_shifted[7:0]))
                                       : XLEN'(w_shifted[7:0]);
            SZ_H: o_ld_data = w_signed ? XLEN'($signed(w_shifted[15:0]))
                                       : XLEN'(w_shifted[15:0]);
            SZ_W: o_ld_data = w_signed ? XLEN'($signed(w_shifted[31:0]))
                                       : XLEN'(w_shifted[31:0]);
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/stage_mem_lsu.sv
// ----------------------------------------------------------------------------
// stage_mem_lsu
// MEM pipeline stage with a load/store unit. Memory ops issue one request over
// a req/ack handshake and stall the pipe until ack; other ops pass through
// with one registered cycle of latency.
// Optional feature: define MISALIGN_TRAP_EN to flag misaligned accesses on
// exc_o instead of silently aligning them.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_i .. rt_data_i     EX/MEM instruction fields
//   stall_o                  combinational hold for EX/MEM and earlier
//   mem_req_o .. mem_be_o    registered data-memory request
//   mem_ack_i, mem_rdata_i   memory completion and load data
//   valid_o .. reg_wdata_o   registered MEM/WB fields
//   exc_o                    misaligned-access exception (trap build only)
// ----------------------------------------------------------------------------
module stage_mem_lsu
    import stage_mem_lsu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MEM_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  we_i,
    input  logic [XLEN-1:0]       reg_wdata_i,
    input  logic [MEM_ADDR_W-1:0] mem_addr_i,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [XLEN-1:0]       rt_data_i,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [XLEN/8-1:0]     mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  we_o,
    output logic [XLEN-1:0]       reg_wdata_o,
    output logic                  exc_o
);

    localparam int unsigned NB     = XLEN / 8;
    localparam int unsigned LANE_W = $clog2(NB);
    localparam logic        XLEN64 = (XLEN == 64);

    state_e                r_state, w_state_nxt;

    // Copies of the issuing instruction, held for the whole transaction.
    logic [ALUOP_W-1:0]    r_op, w_op_nxt;
    logic [LANE_W-1:0]     r_lane, w_lane_nxt;
    logic                  r_lwe, w_lwe_nxt;
    logic [REG_ADDR_W-1:0] r_lwaddr, w_lwaddr_nxt;
    logic [XLEN-1:0]       r_lalu, w_lalu_nxt;

    logic                  r_mem_req, w_mem_req_nxt;
    logic                  r_mem_we, w_mem_we_nxt;
    logic [MEM_ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [XLEN-1:0]       r_mem_wdata, w_mem_wdata_nxt;
    logic [NB-1:0]         r_mem_be, w_mem_be_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_we, w_we_nxt;
    logic [REG_ADDR_W-1:0] r_reg_waddr, w_reg_waddr_nxt;
    logic [XLEN-1:0]       r_reg_wdata, w_reg_wdata_nxt;

    logic                  w_is_wait;
    logic                  w_in_mem;
    logic                  w_in_store;
    logic                  w_issue;
    logic [ALUOP_W-1:0]    w_op_sel;
    logic [LANE_W-1:0]     w_lane_sel;
    logic [NB-1:0]         w_al_be;
    logic [XLEN-1:0]       w_al_wdata;
    logic [XLEN-1:0]       w_al_ld;

    assign w_is_wait  = (r_state == ST_WAIT);
    assign w_in_mem   = is_mem(aluop_i, XLEN64);
    assign w_in_store = is_store(aluop_i, XLEN64);

`ifdef MISALIGN_TRAP_EN
    logic r_exc, w_exc_nxt;
    logic w_misal;
    assign w_misal = misaligned(op_size(aluop_i), 3'(mem_addr_i[LANE_W-1:0]));
    assign w_issue = !w_is_wait && valid_i && w_in_mem && !w_misal;
    assign exc_o   = r_exc;
`else
    assign w_issue = !w_is_wait && valid_i && w_in_mem;
    assign exc_o   = 1'b0;
`endif

    assign stall_o = w_issue || (w_is_wait && !mem_ack_i);

    // One aligner serves both directions: inputs while idle, latched op in WAIT.
    assign w_op_sel   = w_is_wait ? r_op   : aluop_i;
    assign w_lane_sel = w_is_wait ? r_lane : mem_addr_i[LANE_W-1:0];

    stage_mem_lsu_mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_op      (w_op_sel),
        .i_lane    (w_lane_sel),
        .i_st_data (rt_data_i),
        .i_rdata   (mem_rdata_i),
        .o_be      (w_al_be),
        .o_wdata   (w_al_wdata),
        .o_ld_data (w_al_ld)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_lane_nxt      = r_lane;
        w_lwe_nxt       = r_lwe;
        w_lwaddr_nxt    = r_lwaddr;
        w_lalu_nxt      = r_lalu;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_valid_nxt     = 1'b0;
        w_we_nxt        = 1'b0;
        w_reg_waddr_nxt = r_reg_waddr;
        w_reg_wdata_nxt = r_reg_wdata;
`ifdef MISALIGN_TRAP_EN
        w_exc_nxt       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt     = ST_WAIT;
                    w_op_nxt        = aluop_i;
                    w_lane_nxt      = mem_addr_i[LANE_W-1:0];
                    w_lwe_nxt       = we_i;
                    w_lwaddr_nxt    = reg_waddr_i;
                    w_lalu_nxt      = reg_wdata_i;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = w_in_store;
                    w_mem_addr_nxt  = {mem_addr_i[MEM_ADDR_W-1:LANE_W], LANE_W'(0)};
                    w_mem_wdata_nxt = w_al_wdata;
                    w_mem_be_nxt    = w_al_be;
                end
`ifdef MISALIGN_TRAP_EN
                else if (valid_i && w_in_mem) begin
                    w_valid_nxt     = 1'b1;
                    w_exc_nxt       = 1'b1;
                    w_reg_waddr_nxt = reg_waddr_i;
                end
`endif
                else if (valid_i) begin
                    w_valid_nxt     = 1'b1;
                    w_we_nxt        = we_i;
                    w_reg_waddr_nxt = reg_waddr_i;
                    w_reg_wdata_nxt = reg_wdata_i;
                end
            end
            ST_WAIT: begin
                // Request drops at the ack edge together with the retire.
                if (mem_ack_i) begin
                    w_state_nxt     = ST_IDLE;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_wdata_nxt = '0;
                    w_mem_be_nxt    = '0;
                    w_valid_nxt     = 1'b1;
                    w_we_nxt        = r_lwe;
                    w_reg_waddr_nxt = r_lwaddr;
                    w_reg_wdata_nxt = is_load(r_op, XLEN64) ? w_al_ld : r_lalu;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latch and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_lane      <= '0;
            r_lwe       <= 1'b0;
            r_lwaddr    <= '0;
            r_lalu      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_valid     <= 1'b0;
            r_we        <= 1'b0;
            r_reg_waddr <= '0;
            r_reg_wdata <= '0;
`ifdef MISALIGN_TRAP_EN
            r_exc       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_lane      <= w_lane_nxt;
            r_lwe       <= w_lwe_nxt;
            r_lwaddr    <= w_lwaddr_nxt;
            r_lalu      <= w_lalu_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_valid     <= w_valid_nxt;
            r_we        <= w_we_nxt;
            r_reg_waddr <= w_reg_waddr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
`ifdef MISALIGN_TRAP_EN
            r_exc       <= w_exc_nxt;
`endif
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;
    assign valid_o     = r_valid;
    assign we_o        = r_we;
    assign reg_waddr_o = r_reg_waddr;
    assign reg_wdata_o = r_reg_wdata;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// ----------------------------------------------------------------------------
// tb_stage_mem_lsu
// Self-checking bench for stage_mem_lsu (XLEN=32) with a byte-arithmetic
// reference model for lane enables, replicated store data and load extension.
// ----------------------------------------------------------------------------
module tb_stage_mem_lsu;
    import stage_mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic        we_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [3:0]  aluop_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        valid_o;
    logic [4:0]  reg_waddr_o;
    logic        we_o;
    logic [31:0] reg_wdata_o;
    logic        exc_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          stall_cycles;
        logic        req_issue;
        logic        req_steady;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic        mwe;
        logic        valid;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] res;
        logic        req_after;
    } obs_t;

    stage_mem_lsu #(
        .XLEN       (32),
        .REG_ADDR_W (5),
        .MEM_ADDR_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .reg_waddr_i (reg_waddr_i),
        .we_i        (we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_addr_i  (mem_addr_i),
        .aluop_i     (aluop_i),
        .rt_data_i   (rt_data_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_be_o    (mem_be_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .valid_o     (valid_o),
        .reg_waddr_o (reg_waddr_o),
        .we_o        (we_o),
        .reg_wdata_o (reg_wdata_o),
        .exc_o       (exc_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned sz_of(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 4;
    endfunction

    function automatic int unsigned lane_of(input logic [3:0] op, input logic [31:0] addr);
        int unsigned s = sz_of(op);
        return ((addr / s) * s) % 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] addr);
        int unsigned s = sz_of(op);
        return 4'(((1 << s) - 1) << lane_of(op, addr));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] st);
        int unsigned s = sz_of(op);
        longint unsigned m = (64'd1 << (8 * s)) - 1;
        longint unsigned v = 0;
        for (int i = 0; i < int'(4 / s); i++) v = v | ((64'(st) & m) << (8 * s * i));
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int unsigned     s   = sz_of(op);
        longint unsigned m   = (64'd1 << (8 * s)) - 1;
        longint unsigned v   = (64'(rd) >> (8 * lane_of(op, addr))) & m;
        logic            sgn = (op == OP_LB || op == OP_LH || op == OP_LW);
        if (sgn && v[8*s-1]) v = v | ~m;
        return 32'(v);
    endfunction

    function automatic logic is_st(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    // ---------------- drivers (observe only) ----------------
    // Runs one memory op; ack arrives in the wait_n-th cycle of WAIT.
    task automatic mem_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [31:0] alu, input logic we, input logic [4:0] rd,
                           input logic [31:0] rdata, input int wait_n, output obs_t ob);
        ob.stall_cycles = 0;
        ob.req_steady   = 1'b1;
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; rt_data_i = rt;
        reg_wdata_i = alu; we_i = we; reg_waddr_i = rd; mem_ack_i = 1'b0;
        #1;
        if (stall_o) ob.stall_cycles++;
        ob.req_issue = mem_req_o;
        @(posedge clk); #1;
        ob.maddr = mem_addr_o; ob.be = mem_be_o; ob.mwdata = mem_wdata_o; ob.mwe = mem_we_o;
        for (int i = 1; i <= wait_n; i++) begin
            if (i == wait_n) begin
                mem_ack_i = 1'b1; mem_rdata_i = rdata;
            end else begin
                mem_rdata_i = $urandom;
            end
            #1;
            if (stall_o) ob.stall_cycles++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== ob.maddr || mem_be_o !== ob.be)
                ob.req_steady = 1'b0;
            @(posedge clk); #1;
        end
        ob.valid = valid_o; ob.we = we_o; ob.waddr = reg_waddr_o;
        ob.res = reg_wdata_o; ob.req_after = mem_req_o;
        mem_ack_i = 1'b0; valid_i = 1'b0;
    endtask

    task automatic alu_step(input logic v, input logic [31:0] val, input logic [4:0] rd,
                            input logic we, input logic ack, output logic st, output logic rq);
        valid_i = v; aluop_i = OP_ALU; reg_wdata_i = val; reg_waddr_i = rd;
        we_i = we; mem_ack_i = ack; mem_addr_i = $urandom;
        #1;
        st = stall_o; rq = mem_req_o;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({valid_o, we_o, mem_req_o, mem_we_o, exc_o, stall_o} !== 6'b0)
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {valid_o, we_o, mem_req_o, mem_we_o, exc_o, stall_o});
        else n_pass++;
        n_total++;
        if ({mem_addr_o, mem_wdata_o, reg_wdata_o, mem_be_o, reg_waddr_o} !== 105'b0)
            $display("FAIL reset_data addr=%h wdata=%h rwdata=%h be=%h waddr=%h",
                     mem_addr_o, mem_wdata_o, reg_wdata_o, mem_be_o, reg_waddr_o);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        obs_t ob;
        mem_txn(OP_LW, 32'h100, 32'h0, 32'h0, 1'b1, 5'd3, 32'hDEADBEEF, 4, ob);
        n_total++;
        if (ob.stall_cycles != 4) $display("FAIL lw_stall got=%0d exp=4", ob.stall_cycles);
        else n_pass++;
        n_total++;
        if (ob.req_issue !== 1'b0) $display("FAIL lw_req_issue got=%b exp=0", ob.req_issue);
        else n_pass++;
        n_total++;
        if (ob.be !== 4'hF || ob.maddr !== 32'h100 || ob.mwe !== 1'b0)
            $display("FAIL lw_req got be=%h addr=%h we=%b exp be=f addr=00000100 we=0",
                     ob.be, ob.maddr, ob.mwe);
        else n_pass++;
        n_total++;
        if (ob.req_steady !== 1'b1 || ob.req_after !== 1'b0)
            $display("FAIL lw_req_hold steady=%b after=%b exp 1/0", ob.req_steady, ob.req_after);
        else n_pass++;
        n_total++;
        if (ob.valid !== 1'b1 || ob.res !== 32'hDEADBEEF || ob.waddr !== 5'd3 || ob.we !== 1'b1)
            $display("FAIL lw_result got v=%b d=%h rd=%0d we=%b exp v=1 d=deadbeef rd=3 we=1",
                     ob.valid, ob.res, ob.waddr, ob.we);
        else n_pass++;
    endtask

    task automatic test_load_byte();
        obs_t ob;
        mem_txn(OP_LB, 32'h103, 32'h0, 32'h0, 1'b1, 5'd4, 32'h80FFFF00, 1, ob);
        n_total++;
        if (ob.res !== 32'hFFFFFF80) $display("FAIL lb_sext got=%h exp=ffffff80", ob.res);
        else n_pass++;
        n_total++;
        if (ob.be !== 4'b1000) $display("FAIL lb_be got=%b exp=1000", ob.be);
        else n_pass++;
        mem_txn(OP_LBU, 32'h103, 32'h0, 32'h0, 1'b1, 5'd4, 32'h80FFFF00, 2, ob);
        n_total++;
        if (ob.res !== 32'h00000080) $display("FAIL lbu_zext got=%h exp=00000080", ob.res);
        else n_pass++;
    endtask

    task automatic test_store_half();
        obs_t ob;
        mem_txn(OP_SH, 32'h102, 32'h1234ABCD, 32'h77, 1'b0, 5'd9, 32'h0, 2, ob);
        n_total++;
        if (ob.mwe !== 1'b1 || ob.be !== 4'b1100)
            $display("FAIL sh_we_be got we=%b be=%b exp we=1 be=1100", ob.mwe, ob.be);
        else n_pass++;
        n_total++;
        if (ob.mwdata !== 32'hABCDABCD || ob.maddr !== 32'h100)
            $display("FAIL sh_data got wdata=%h addr=%h exp abcdabcd/00000100", ob.mwdata, ob.maddr);
        else n_pass++;
        n_total++;
        if (ob.valid !== 1'b1 || ob.we !== 1'b0 || ob.res !== 32'h77)
            $display("FAIL sh_retire got v=%b we=%b d=%h exp 1/0/00000077", ob.valid, ob.we, ob.res);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic st, rq;
        alu_step(1'b1, 32'h55, 5'd7, 1'b1, 1'b0, st, rq);
        n_total++;
        if (st !== 1'b0 || rq !== 1'b0) $display("FAIL add_nostall got stall=%b req=%b exp 0/0", st, rq);
        else n_pass++;
        n_total++;
        if (valid_o !== 1'b1 || reg_waddr_o !== 5'd7 || reg_wdata_o !== 32'h55 || we_o !== 1'b1)
            $display("FAIL add_out got v=%b rd=%0d d=%h we=%b exp 1/7/00000055/1",
                     valid_o, reg_waddr_o, reg_wdata_o, we_o);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            logic        v   = 1'(i == 3 ? 0 : $urandom_range(0, 3) != 0);
            logic [31:0] d   = $urandom;
            logic [4:0]  rd  = 5'($urandom);
            logic        we  = 1'($urandom);
            logic        ack = 1'($urandom);
            alu_step(v, d, rd, we, ack, st, rq);
            n_total++;
            if (st !== 1'b0 || rq !== 1'b0 || mem_req_o !== 1'b0)
                $display("FAIL b2b_nomem i=%0d stall=%b req=%b exp 0/0", i, st, rq);
            else n_pass++;
            n_total++;
            if (valid_o !== v || we_o !== (v & we) || (v && (reg_waddr_o !== rd || reg_wdata_o !== d)))
                $display("FAIL b2b_out i=%0d got v=%b we=%b rd=%0d d=%h exp v=%b we=%b rd=%0d d=%h",
                         i, valid_o, we_o, reg_waddr_o, reg_wdata_o, v, v & we, rd, d);
            else n_pass++;
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        obs_t ob;
        valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h200; we_i = 1'b1; reg_waddr_i = 5'd5;
        @(posedge clk); #1;
        n_total++;
        if (mem_req_o !== 1'b1) $display("FAIL rstw_req_pre got=%b exp=1", mem_req_o);
        else n_pass++;
        rst = 1'b1; valid_i = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if ({mem_req_o, valid_o, we_o, mem_we_o} !== 4'b0 || mem_be_o !== 4'h0 ||
            mem_addr_o !== 32'h0 || reg_wdata_o !== 32'h0)
            $display("FAIL rstw_clear got req=%b v=%b we=%b be=%h addr=%h exp all zero",
                     mem_req_o, valid_o, we_o, mem_be_o, mem_addr_o);
        else n_pass++;
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        #1;
        n_total++;
        if (stall_o !== 1'b0) $display("FAIL rstw_late_ack_stall got=%b exp=0", stall_o);
        else n_pass++;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        n_total++;
        if (valid_o !== 1'b0 || mem_req_o !== 1'b0 || reg_wdata_o !== 32'h0)
            $display("FAIL rstw_late_ack got v=%b req=%b d=%h exp 0/0/00000000",
                     valid_o, mem_req_o, reg_wdata_o);
        else n_pass++;
        mem_txn(OP_LW, 32'h104, 32'h0, 32'h0, 1'b1, 5'd6, 32'h13572468, 2, ob);
        n_total++;
        if (ob.res !== 32'h13572468 || ob.maddr !== 32'h104 || ob.stall_cycles != 2)
            $display("FAIL rstw_next_lw got d=%h addr=%h stall=%0d exp 13572468/00000104/2",
                     ob.res, ob.maddr, ob.stall_cycles);
        else n_pass++;
    endtask

    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h101; we_i = 1'b1; reg_waddr_i = 5'd2;
        #1;
        n_total++;
        if (stall_o !== 1'b0) $display("FAIL mis_stall got=%b exp=0", stall_o);
        else n_pass++;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_total++;
        if (exc_o !== 1'b1 || valid_o !== 1'b1 || we_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL mis_trap got exc=%b v=%b we=%b req=%b exp 1/1/0/0",
                     exc_o, valid_o, we_o, mem_req_o);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (exc_o !== 1'b0) $display("FAIL mis_exc_clear got=%b exp=0", exc_o);
        else n_pass++;
`else
        obs_t ob;
        mem_txn(OP_LW, 32'h101, 32'h0, 32'h0, 1'b1, 5'd2, 32'h89ABCDEF, 1, ob);
        n_total++;
        if (ob.maddr !== 32'h100 || ob.be !== 4'hF || ob.res !== 32'h89ABCDEF)
            $display("FAIL mis_trunc got addr=%h be=%h d=%h exp 00000100/f/89abcdef",
                     ob.maddr, ob.be, ob.res);
        else n_pass++;
        n_total++;
        if (exc_o !== 1'b0) $display("FAIL mis_noexc got=%b exp=0", exc_o);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [3:0] ops [9] = '{OP_ALU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        obs_t ob;
        logic st, rq;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op   = ops[$urandom_range(0, 8)];
            logic [31:0] addr = $urandom;
            logic [31:0] rt   = $urandom;
            logic [31:0] alu  = $urandom;
            logic [31:0] rd   = $urandom;
            logic [4:0]  ra   = 5'($urandom);
            logic        we   = 1'($urandom);
            int          wn   = $urandom_range(1, 5);
`ifdef MISALIGN_TRAP_EN
            addr = addr & ~(sz_of(op) - 1);
`endif
            if (op == OP_ALU) begin
                alu_step(1'b1, alu, ra, we, 1'($urandom), st, rq);
                n_total++;
                if (st !== 1'b0 || rq !== 1'b0 || valid_o !== 1'b1 || we_o !== we ||
                    reg_wdata_o !== alu || reg_waddr_o !== ra)
                    $display("FAIL rnd_alu i=%0d got st=%b v=%b we=%b d=%h exp 0/1/%b/%h",
                             i, st, valid_o, we_o, reg_wdata_o, we, alu);
                else n_pass++;
                valid_i = 1'b0;
            end else begin
                mem_txn(op, addr, rt, alu, we, ra, rd, wn, ob);
                n_total++;
                if (ob.stall_cycles != wn || !ob.req_steady || ob.req_after !== 1'b0)
                    $display("FAIL rnd_hs i=%0d op=%0d stall=%0d exp=%0d steady=%b after=%b",
                             i, op, ob.stall_cycles, wn, ob.req_steady, ob.req_after);
                else n_pass++;
                n_total++;
                if (ob.maddr !== {addr[31:2], 2'b00} || ob.be !== exp_be(op, addr) ||
                    ob.mwe !== is_st(op))
                    $display("FAIL rnd_req i=%0d op=%0d got addr=%h be=%b we=%b exp %h/%b/%b",
                             i, op, ob.maddr, ob.be, ob.mwe, {addr[31:2], 2'b00},
                             exp_be(op, addr), is_st(op));
                else n_pass++;
                if (is_st(op)) begin
                    n_total++;
                    if (ob.mwdata !== exp_wdata(op, rt) || ob.res !== alu)
                        $display("FAIL rnd_st i=%0d op=%0d got wdata=%h d=%h exp %h/%h",
                                 i, op, ob.mwdata, ob.res, exp_wdata(op, rt), alu);
                    else n_pass++;
                end else begin
                    n_total++;
                    if (ob.res !== exp_load(op, addr, rd))
                        $display("FAIL rnd_ld i=%0d op=%0d addr=%h rdata=%h got=%h exp=%h",
                                 i, op, addr, rd, ob.res, exp_load(op, addr, rd));
                    else n_pass++;
                end
                n_total++;
                if (ob.valid !== 1'b1 || ob.we !== we || ob.waddr !== ra)
                    $display("FAIL rnd_wb i=%0d got v=%b we=%b rd=%0d exp 1/%b/%0d",
                             i, ob.valid, ob.we, ob.waddr, we, ra);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_back_to_back();
        test_reset_mid_wait();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
